// File: rtl/shift_arbiter_pkg.sv
// rtl/shift_arbiter_pkg.sv - shared types and helpers for the shift arbiter
package shift_arbiter_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int MAX_NREQ     = 8;
    localparam int RR_IDX_WIDTH = 3;

    // Index width that stays legal for a single-entry range.
    function automatic int min_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of valid at or after ptr, wrapping at nreq; returns {hit, index}.
    function automatic logic [RR_IDX_WIDTH:0] rr_first(
        input logic [MAX_NREQ-1:0]     valid,
        input logic [RR_IDX_WIDTH-1:0] ptr,
        input int                      nreq
    );
        logic                    hit;
        logic [RR_IDX_WIDTH-1:0] idx;
        int                      j;
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= nreq) begin
                j = j - nreq;
            end
            if ((i < nreq) && !hit && valid[j[RR_IDX_WIDTH-1:0]]) begin
                hit = 1'b1;
                idx = j[RR_IDX_WIDTH-1:0];
            end
        end
        return {hit, idx};
    endfunction

endpackage

// File: rtl/shift.sv
// rtl/shift.sv - combinational logical shifter, left or right by shamt
module shift #(
    parameter int WIDTH       = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic [WIDTH-1:0]       data,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic                   left,
    output logic [WIDTH-1:0]       result
);

    assign result = left ? (data << shamt) : (data >> shamt);

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sharing of one shifter with a registered tagged response
// Optional SHIFT_ARBITER_SRA_EN adds req_arith for arithmetic right shifts.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NREQ        = 4,
    parameter int SHAMT_WIDTH = min_width(WIDTH),
    parameter int ID_WIDTH    = min_width(NREQ),
    parameter int CNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*WIDTH-1:0]       req_data,
    input  logic [NREQ*SHAMT_WIDTH-1:0] req_shamt,
    input  logic [NREQ-1:0]             req_shope,
`ifdef SHIFT_ARBITER_SRA_EN
    input  logic [NREQ-1:0]             req_arith,
`endif
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WIDTH-1:0]            rsp_data,
    output logic [ID_WIDTH-1:0]         rsp_id,
    output logic [CNT_WIDTH-1:0]        op_count
);

    state_t                  state_q;
    state_t                  state_d;
    logic [ID_WIDTH-1:0]     ptr_q;
    logic [ID_WIDTH-1:0]     ptr_d;
    logic [RR_IDX_WIDTH:0]   pick;
    logic                    grant_hit;
    logic [ID_WIDTH-1:0]     grant_id;
    logic                    drain;
    logic                    can_accept;
    logic                    accept;
    logic [WIDTH-1:0]        sel_data;
    logic [SHAMT_WIDTH-1:0]  sel_shamt;
    logic                    sel_left;
    logic [WIDTH-1:0]        shift_result;
    logic [WIDTH-1:0]        load_data;

    assign rsp_valid  = (state_q == FULL);
    assign drain      = rsp_valid & rsp_ready;
    assign can_accept = (state_q == EMPTY) | drain;

    always_comb begin
        pick = rr_first(MAX_NREQ'(req_valid), RR_IDX_WIDTH'(ptr_q), NREQ);
    end

    assign grant_hit = pick[RR_IDX_WIDTH];
    assign grant_id  = ID_WIDTH'(pick[RR_IDX_WIDTH-1:0]);

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_hit && !rst && can_accept && (grant_id == ID_WIDTH'(k))) begin
                req_ready[k] = 1'b1;
            end
        end
    end

    assign accept = |(req_valid & req_ready);

    // Only the granted requester's operands reach the shifter.
    always_comb begin
        sel_data  = '0;
        sel_shamt = '0;
        sel_left  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_id == ID_WIDTH'(k)) begin
                sel_data  = req_data[k*WIDTH +: WIDTH];
                sel_shamt = req_shamt[k*SHAMT_WIDTH +: SHAMT_WIDTH];
                sel_left  = req_shope[k];
            end
        end
    end

    shift #(
        .WIDTH       (WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shift (
        .data   (sel_data),
        .shamt  (sel_shamt),
        .left   (sel_left),
        .result (shift_result)
    );

`ifdef SHIFT_ARBITER_SRA_EN
    logic sel_arith;

    always_comb begin
        sel_arith = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_id == ID_WIDTH'(k)) begin
                sel_arith = req_arith[k];
            end
        end
    end

    // Fill the vacated MSBs with the sign bit on top of the logical result.
    always_comb begin
        load_data = shift_result;
        if (sel_arith && !sel_left && sel_data[WIDTH-1]) begin
            load_data = shift_result | ~({WIDTH{1'b1}} >> sel_shamt);
        end
    end
`else
    assign load_data = shift_result;
`endif

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant_id == ID_WIDTH'(NREQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (drain && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            ptr_q    <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            op_count <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                rsp_data <= load_data;
                rsp_id   <= grant_id;
            end
            if (drain) begin
                op_count <= op_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed and randomized checks of shift_arbiter against a reference model
module tb_shift_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 5;
    localparam int IW = 2;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_data = '0;
    logic [N*SW-1:0] req_shamt = '0;
    logic [N-1:0]    req_shope = '0;
`ifdef SHIFT_ARBITER_SRA_EN
    logic [N-1:0]    req_arith = '0;
`endif
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [W-1:0]    rsp_data;
    logic [IW-1:0]   rsp_id;
    logic [CW-1:0]   op_count;

    shift_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .req_shope (req_shope),
`ifdef SHIFT_ARBITER_SRA_EN
        .req_arith (req_arith),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one pending result, a rotating priority pointer, a wrapping counter.
    bit           m_full = 0;
    logic [W-1:0] m_data = '0;
    int           m_id   = 0;
    int           m_ptr  = 0;
    int           m_cnt  = 0;
    logic [N-1:0] acc_mask = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input bit l, input bit a);
        if (l) return d << s;
        if (a) return W'($signed(d) >>> s);
        return d >> s;
    endfunction

    function automatic bit arith_of(input int k);
`ifdef SHIFT_ARBITER_SRA_EN
        return req_arith[k];
`else
        return (k < 0);
`endif
    endfunction

    task automatic set_req(input int k, input bit v, input logic [W-1:0] d, input int s, input bit l, input bit a);
        req_valid[k]            = v;
        req_data[k*W +: W]      = d;
        req_shamt[k*SW +: SW]   = SW'(s);
        req_shope[k]            = l;
`ifdef SHIFT_ARBITER_SRA_EN
        req_arith[k]            = a;
`else
        if (a) req_shope[k] = l;
`endif
    endtask

    task automatic rand_req(input int k);
        set_req(k, 1'b1, $urandom, $urandom_range(0, W - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // One clock: check the grant before the edge, advance the model, check the response after it.
    task automatic tick();
        int           g;
        bit           found;
        bit           can;
        logic [N-1:0] exp_rdy;
        #1;
        found = 0;
        g = 0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (!found && req_valid[j]) begin
                found = 1;
                g = j;
            end
        end
        can = !m_full || rsp_ready;
        exp_rdy = (found && can && !rst) ? N'(1 << g) : '0;
        chk("req_ready", req_ready, exp_rdy);
        @(posedge clk);
        acc_mask = exp_rdy & req_valid;
        if (rst) begin
            m_full = 0; m_data = '0; m_id = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (m_full && rsp_ready) begin
                m_cnt  = (m_cnt + 1) % (1 << CW);
                m_full = 0;
            end
            if (acc_mask != 0) begin
                m_full = 1;
                m_id   = g;
                m_data = ref_shift(req_data[g*W +: W], int'(req_shamt[g*SW +: SW]), req_shope[g], arith_of(g));
                m_ptr  = (g + 1) % N;
            end
        end
        #1;
        chk("rsp_valid", rsp_valid, m_full);
        if (m_full) begin
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_id", rsp_id, m_id);
        end
        chk("op_count", op_count, m_cnt);
    endtask

    task automatic refill_all();
        for (int k = 0; k < N; k++) if (acc_mask[k]) rand_req(k);
    endtask

    task automatic refill_rand();
        for (int k = 0; k < N; k++) begin
            if (!req_valid[k] || acc_mask[k]) begin
                if ($urandom_range(0, 1) == 1) rand_req(k);
                else req_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset with every requester asking.
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 32'hDEAD_0000 + W'(k), 3, 1'b1, 1'b0);
        rsp_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_data", rsp_data, 0);
        chk("reset_id", rsp_id, 0);
        chk("reset_ready", req_ready, 0);
        rst = 1'b0;
        req_valid = '0;

        // Single operations on requester 0.
        set_req(0, 1'b1, 32'h0000_00F0, 4, 1'b1, 1'b0);
        tick();
        req_valid[0] = 1'b0;
        chk("single_left", rsp_data, 32'h0000_0F00);
        chk("single_id", rsp_id, 0);
        set_req(0, 1'b1, 32'h0000_00F0, 4, 1'b0, 1'b0);
        tick();
        req_valid[0] = 1'b0;
        chk("single_right", rsp_data, 32'h0000_000F);
        tick();

        // Round robin with everyone valid and no backpressure.
        do_reset();
        for (int k = 0; k < N; k++) rand_req(k);
        for (int i = 0; i < 9; i++) begin
            tick();
            refill_all();
            if (i < 8) chk("rr_id", rsp_id, i % N);
        end
        chk("rr_count", op_count, 8);

        // Backpressure: result held, nothing accepted, then drain plus accept together.
        do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 32'h1234_5678, 8, 1'b1, 1'b0);
        tick();
        set_req(1, 1'b1, 32'h0000_0001, 1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", rsp_data, 32'h3456_7800);
            chk("bp_hold_id", rsp_id, 1);
            chk("bp_no_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_drain_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        chk("bp_new_data", rsp_data, 32'h0000_0002);
        chk("bp_count", op_count, 1);
        tick();

        // Shift extremes.
        set_req(0, 1'b1, 32'h0000_0001, 31, 1'b1, 1'b0);
        tick();
        req_valid = '0;
        chk("ext_left31", rsp_data, 32'h8000_0000);
        set_req(0, 1'b1, 32'h8000_0000, 31, 1'b0, 1'b0);
        tick();
        req_valid = '0;
        chk("ext_right31", rsp_data, 32'h0000_0001);
        set_req(0, 1'b1, 32'hA5A5_5A5A, 0, 1'b0, 1'b0);
        tick();
        req_valid = '0;
        chk("ext_shamt0", rsp_data, 32'hA5A5_5A5A);
`ifdef SHIFT_ARBITER_SRA_EN
        set_req(0, 1'b1, 32'h8000_0000, 31, 1'b0, 1'b1);
        tick();
        req_valid = '0;
        chk("ext_sra31", rsp_data, 32'hFFFF_FFFF);
`endif
        tick();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            rsp_ready = ($urandom_range(0, 9) < 7);
            refill_rand();
            tick();
        end

        // Reset with a result pending.
        do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        set_req(2, 1'b1, 32'h0000_0011, 2, 1'b1, 1'b0);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < N; k++) rand_req(k);
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_grant", req_ready, 4'b0001);
        tick();
        chk("mid_rst_id", rsp_id, 0);

        // Counter wrap after 2^CW handshakes.
        do_reset();
        for (int k = 0; k < N; k++) rand_req(k);
        for (int i = 0; i < 70000 && m_cnt != (1 << CW) - 1; i++) begin
            tick();
            refill_all();
        end
        chk("cnt_at_max", op_count, 16'hFFFF);
        tick();
        chk("cnt_wrap", op_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
